// File: rtl/time_set_pkg.sv
// Shared types, BCD limits and helpers for the front-panel time-setting logic.
package time_set_pkg;

   // Edit FSM states; 2'd3 is unused and falls back to S_IDLE.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HOUR = 2'd1,
      S_MIN  = 2'd2
   } state_t;

   localparam logic [3:0] HOUR_MAX_T = 4'd2;
   localparam logic [3:0] HOUR_MAX_U = 4'd3;
   localparam logic [3:0] MIN_MAX_T  = 4'd5;
   localparam logic [3:0] MIN_MAX_U  = 4'd9;

   // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // True when {t,u} is valid BCD and does not exceed {max_t,max_u}.
   function automatic logic bcd_valid(input logic [3:0] t, input logic [3:0] u,
                                      input logic [3:0] max_t, input logic [3:0] max_u);
      return (u <= 4'd9) && ((t < max_t) || ((t == max_t) && (u <= max_u)));
   endfunction

   // BCD increment of a two-digit field, wrapping {max_t,max_u} back to 00.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                          input logic [3:0] max_t, input logic [3:0] max_u);
      logic [3:0] t;
      logic [3:0] u;
      t = v[7:4];
      u = v[3:0];
      if ((t == max_t) && (u == max_u)) return 8'h00;
      if (u == 4'd9) return {t + 4'd1, 4'd0};
      return {t, u + 4'd1};
   endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability filter and a
// single-cycle pulse on each debounced press (no pulse on release).
module btn_debounce
   import time_set_pkg::*;
#(
   parameter int DB_CYCLES = 50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic rise
);

   localparam int CW = cnt_w(DB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync_a;
   logic          sync_b;
   logic          level;
   logic [CW-1:0] stab_cnt;

   // Bring the asynchronous button level into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
      end
   end

   // Accept a new level only after DB_CYCLES consecutive differing samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stab_cnt <= '0;
         level    <= 1'b0;
         rise     <= 1'b0;
      end else begin
         rise <= 1'b0;
         if (sync_b == level) begin
            stab_cnt <= '0;
         end else if (stab_cnt == CNT_LAST) begin
            stab_cnt <= '0;
            level    <= sync_b;
            rise     <= sync_b;
         end else begin
            stab_cnt <= stab_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: debounced mode/up buttons drive an
// edit FSM that holds and loads the hour or minute BCD counter.
module time_set_ctrl
   import time_set_pkg::*;
#(
   parameter int DB_CYCLES      = 50000,
   parameter int TIMEOUT_CYCLES = 500000000,
   parameter int BLINK_CYCLES   = 25000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic [3:0] cur_h1,
   input  logic [3:0] cur_h2,
   input  logic [3:0] cur_m1,
   input  logic [3:0] cur_m2,
   output logic       set_hour,
   output logic       set_min,
   output logic [3:0] set_num1,
   output logic [3:0] set_num2,
   output logic [1:0] mode,
   output logic       blink
);

   localparam int TO_W = cnt_w(TIMEOUT_CYCLES);
   localparam int BL_W = cnt_w(BLINK_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

   state_t          state, state_nxt;
   logic [7:0]      edit_h, edit_h_nxt;
   logic [7:0]      edit_m, edit_m_nxt;
   logic [TO_W-1:0] to_cnt, to_cnt_nxt;
   logic [BL_W-1:0] bl_cnt, bl_cnt_nxt;
   logic            blink_nxt;
   logic            mode_pulse;
   logic            up_pulse;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_mode),
      .rise    (mode_pulse)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_up),
      .rise    (up_pulse)
   );

   // State, edit values, idle timeout and blink generator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         edit_h <= '0;
         edit_m <= '0;
         to_cnt <= '0;
         bl_cnt <= '0;
         blink  <= 1'b0;
      end else begin
         state  <= state_nxt;
         edit_h <= edit_h_nxt;
         edit_m <= edit_m_nxt;
         to_cnt <= to_cnt_nxt;
         bl_cnt <= bl_cnt_nxt;
         blink  <= blink_nxt;
      end
   end

   // Next-state, edit arithmetic and output decode; mode beats up in the same cycle.
   always_comb begin
      state_nxt  = state;
      edit_h_nxt = edit_h;
      edit_m_nxt = edit_m;
      to_cnt_nxt = to_cnt;
      bl_cnt_nxt = bl_cnt;
      blink_nxt  = blink;
      set_hour   = 1'b0;
      set_min    = 1'b0;
      set_num1   = 4'd0;
      set_num2   = 4'd0;
      mode       = 2'd0;

      case (state)
         S_IDLE: begin
            if (mode_pulse) begin
               state_nxt  = S_HOUR;
               edit_h_nxt = bcd_valid(cur_h1, cur_h2, HOUR_MAX_T, HOUR_MAX_U) ?
                            {cur_h1, cur_h2} : 8'h00;
            end
         end
         S_HOUR: begin
            set_hour = 1'b1;
            mode     = 2'd1;
            set_num1 = edit_h[7:4];
            set_num2 = edit_h[3:0];
            if (mode_pulse) begin
               state_nxt  = S_MIN;
               edit_m_nxt = bcd_valid(cur_m1, cur_m2, MIN_MAX_T, MIN_MAX_U) ?
                            {cur_m1, cur_m2} : 8'h00;
            end else if (up_pulse) begin
               edit_h_nxt = bcd_inc(edit_h, HOUR_MAX_T, HOUR_MAX_U);
            end else if (to_cnt == TO_LAST) begin
               state_nxt = S_IDLE;
            end
         end
         S_MIN: begin
            set_min  = 1'b1;
            mode     = 2'd2;
            set_num1 = edit_m[7:4];
            set_num2 = edit_m[3:0];
            if (mode_pulse) begin
               state_nxt = S_IDLE;
            end else if (up_pulse) begin
               edit_m_nxt = bcd_inc(edit_m, MIN_MAX_T, MIN_MAX_U);
            end else if (to_cnt == TO_LAST) begin
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // Idle timeout restarts on any activity and only runs in edit states.
      if (mode_pulse || up_pulse || (state_nxt != state) || (state == S_IDLE))
         to_cnt_nxt = '0;
      else
         to_cnt_nxt = to_cnt + 1'b1;

      // Blink phase restarts on every state change and stays low in idle.
      if ((state_nxt != state) || (state_nxt == S_IDLE)) begin
         bl_cnt_nxt = '0;
         blink_nxt  = 1'b0;
      end else if (bl_cnt == BL_LAST) begin
         bl_cnt_nxt = '0;
         blink_nxt  = ~blink;
      end else begin
         bl_cnt_nxt = bl_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: scripted vector table, bounce/timeout/reset
// sequences, and random button activity against a cycle reference model.
module tb_time_set_ctrl;

   localparam int DB = 4;
   localparam int TO = 64;
   localparam int BL = 8;
   localparam int NV = 23;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_up = 1'b0;
   logic [3:0] cur_h1 = 4'd0, cur_h2 = 4'd0, cur_m1 = 4'd0, cur_m2 = 4'd0;
   logic       set_hour, set_min, blink;
   logic [3:0] set_num1, set_num2;
   logic [1:0] mode;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   time_set_ctrl #(.DB_CYCLES(DB), .TIMEOUT_CYCLES(TO), .BLINK_CYCLES(BL)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_mode (btn_mode),
      .btn_up   (btn_up),
      .cur_h1   (cur_h1),
      .cur_h2   (cur_h2),
      .cur_m1   (cur_m1),
      .cur_m2   (cur_m2),
      .set_hour (set_hour),
      .set_min  (set_min),
      .set_num1 (set_num1),
      .set_num2 (set_num2),
      .mode     (mode),
      .blink    (blink)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Debounce: the filtered level follows the raw input once the DB samples
   // seen two edges ago and earlier all agree. FSM values kept as integers.
   logic [DB+1:0] h_m = '0, h_u = '0;
   logic m_dm = 1'b0, m_du = 1'b0, m_pm = 1'b0, m_pu = 1'b0;
   int   m_st = 0, m_eh = 0, m_em = 0, m_idle = 0, m_age = 0, prev_st = 0;

   function automatic logic [1:0] deb_eval(input logic [DB-1:0] win, input logic deb);
      if ((&win) && !deb) return 2'b11;
      if (!(|win) && deb) return 2'b00;
      return {deb, 1'b0};
   endfunction

   function automatic int cap(input logic [3:0] t, input logic [3:0] u, input int maxv);
      int v;
      v = int'(t) * 10 + int'(u);
      if (t > 4'd9 || u > 4'd9 || v > maxv) return 0;
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st = 0; m_eh = 0; m_em = 0; m_idle = 0; m_age = 0;
         m_dm = 1'b0; m_du = 1'b0; m_pm = 1'b0; m_pu = 1'b0;
         h_m = '0; h_u = '0;
      end else begin
         prev_st = m_st;
         if (m_pm) begin
            if (m_st == 0) begin m_st = 1; m_eh = cap(cur_h1, cur_h2, 23); end
            else if (m_st == 1) begin m_st = 2; m_em = cap(cur_m1, cur_m2, 59); end
            else m_st = 0;
         end else if (m_pu) begin
            if (m_st == 1) m_eh = (m_eh + 1) % 24;
            else if (m_st == 2) m_em = (m_em + 1) % 60;
         end else if (m_st != 0 && m_idle == TO - 1) begin
            m_st = 0;
         end
         if (m_pm || m_pu || m_st != prev_st || m_st == 0) m_idle = 0; else m_idle++;
         if (m_st != prev_st || m_st == 0) m_age = 0; else m_age++;
         h_m = {h_m[DB:0], btn_mode};
         h_u = {h_u[DB:0], btn_up};
         {m_dm, m_pm} = deb_eval(h_m[DB+1:2], m_dm);
         {m_du, m_pu} = deb_eval(h_u[DB+1:2], m_du);
      end
   end

   // Compare all outputs against the model on every falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         int n, sh, sm, bl, e;
         n  = (m_st == 1) ? m_eh : (m_st == 2) ? m_em : 0;
         sh = (m_st == 1) ? 1 : 0;
         sm = (m_st == 2) ? 1 : 0;
         bl = (m_st != 0) ? (m_age / BL) % 2 : 0;
         e  = (sh << 12) | (sm << 11) | ((n / 10) << 7) | ((n % 10) << 3) | (m_st << 1) | bl;
         check("model", 32'({set_hour, set_min, set_num1, set_num2, mode, blink}), 32'(e));
      end
   end

   // ---------------- directed stimulus ----------------
   typedef struct packed {
      logic [3:0] h1, h2, m1, m2;
      logic       pm, pu;
      logic [1:0] emode;
      logic [3:0] en1, en2;
   } vec_t;

   vec_t vt [NV];

   task automatic press(input logic pm, input logic pu);
      @(negedge clk);
      btn_mode = pm;
      btn_up   = pu;
      repeat (DB + 6) @(negedge clk);
      btn_mode = 1'b0;
      btn_up   = 1'b0;
      repeat (DB + 6) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      //            h1    h2    m1    m2    pm    pu    mode  n1    n2
      vt[0]  = '{4'd2, 4'd1, 4'd3, 4'd4, 1'b1, 1'b0, 2'd1, 4'd2, 4'd1};
      vt[1]  = '{4'd2, 4'd1, 4'd3, 4'd4, 1'b0, 1'b1, 2'd1, 4'd2, 4'd2};
      vt[2]  = '{4'd2, 4'd1, 4'd3, 4'd4, 1'b0, 1'b1, 2'd1, 4'd2, 4'd3};
      vt[3]  = '{4'd2, 4'd1, 4'd3, 4'd4, 1'b0, 1'b1, 2'd1, 4'd0, 4'd0};
      vt[4]  = '{4'd2, 4'd1, 4'd3, 4'd4, 1'b1, 1'b0, 2'd2, 4'd3, 4'd4};
      vt[5]  = '{4'd2, 4'd1, 4'd3, 4'd4, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0};
      vt[6]  = '{4'd0, 4'd9, 4'd5, 4'd8, 1'b1, 1'b0, 2'd1, 4'd0, 4'd9};
      vt[7]  = '{4'd0, 4'd9, 4'd5, 4'd8, 1'b0, 1'b1, 2'd1, 4'd1, 4'd0};
      vt[8]  = '{4'd0, 4'd9, 4'd5, 4'd8, 1'b1, 1'b0, 2'd2, 4'd5, 4'd8};
      vt[9]  = '{4'd0, 4'd9, 4'd5, 4'd8, 1'b0, 1'b1, 2'd2, 4'd5, 4'd9};
      vt[10] = '{4'd0, 4'd9, 4'd5, 4'd8, 1'b0, 1'b1, 2'd2, 4'd0, 4'd0};
      vt[11] = '{4'd0, 4'd9, 4'd5, 4'd8, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0};
      vt[12] = '{4'd0, 4'd9, 4'd5, 4'd8, 1'b0, 1'b1, 2'd0, 4'd0, 4'd0};
      vt[13] = '{4'd0, 4'd5, 4'd1, 4'd2, 1'b1, 1'b0, 2'd1, 4'd0, 4'd5};
      vt[14] = '{4'd0, 4'd5, 4'd1, 4'd2, 1'b1, 1'b1, 2'd2, 4'd1, 4'd2};
      vt[15] = '{4'd0, 4'd5, 4'd1, 4'd2, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0};
      vt[16] = '{4'd2, 4'd7, 4'd6, 4'd3, 1'b1, 1'b0, 2'd1, 4'd0, 4'd0};
      vt[17] = '{4'd2, 4'd7, 4'd6, 4'd3, 1'b0, 1'b1, 2'd1, 4'd0, 4'd1};
      vt[18] = '{4'd2, 4'd7, 4'd6, 4'd3, 1'b1, 1'b0, 2'd2, 4'd0, 4'd0};
      vt[19] = '{4'd2, 4'd7, 4'd6, 4'd3, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0};
      vt[20] = '{4'd1, 4'hA, 4'd5, 4'd9, 1'b1, 1'b0, 2'd1, 4'd0, 4'd0};
      vt[21] = '{4'd1, 4'hA, 4'd5, 4'd9, 1'b1, 1'b0, 2'd2, 4'd5, 4'd9};
      vt[22] = '{4'd1, 4'hA, 4'd5, 4'd9, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0};

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_set_hour", 32'(set_hour), 32'd0);
      check("rst_set_min",  32'(set_min),  32'd0);
      check("rst_num1",     32'(set_num1), 32'd0);
      check("rst_num2",     32'(set_num2), 32'd0);
      check("rst_mode",     32'(mode),     32'd0);
      check("rst_blink",    32'(blink),    32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Vector table
      for (int i = 0; i < NV; i++) begin
         cur_h1 = vt[i].h1; cur_h2 = vt[i].h2;
         cur_m1 = vt[i].m1; cur_m2 = vt[i].m2;
         press(vt[i].pm, vt[i].pu);
         #1;
         check($sformatf("vec%0d_mode", i),     32'(mode),     32'(vt[i].emode));
         check($sformatf("vec%0d_set_hour", i), 32'(set_hour), 32'(vt[i].emode == 2'd1));
         check($sformatf("vec%0d_set_min", i),  32'(set_min),  32'(vt[i].emode == 2'd2));
         check($sformatf("vec%0d_num1", i),     32'(set_num1), 32'(vt[i].en1));
         check($sformatf("vec%0d_num2", i),     32'(set_num2), 32'(vt[i].en2));
      end

      // Bouncing mode button, one entry into hour edit, then idle timeout
      cur_h1 = 4'd1; cur_h2 = 4'd2; cur_m1 = 4'd3; cur_m2 = 4'd0;
      for (int i = 0; i < 10; i++) begin
         btn_mode = ~btn_mode;
         repeat (2) @(negedge clk);
      end
      btn_mode = 1'b1;
      for (int k = 1; k <= 80; k++) begin
         int em, eb;
         @(negedge clk);
         #1;
         em = (k >= DB + 3 && k < DB + 3 + TO) ? 1 : 0;
         eb = (em == 1) ? ((k - (DB + 3)) / BL) % 2 : 0;
         check($sformatf("bounce_mode_k%0d", k),  32'(mode),  32'(em));
         check($sformatf("bounce_blink_k%0d", k), 32'(blink), 32'(eb));
         if (k == 30) btn_mode = 1'b0;
      end

      // Asynchronous reset while editing minutes
      cur_h1 = 4'd1; cur_h2 = 4'd5; cur_m1 = 4'd4; cur_m2 = 4'd2;
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      #1;
      check("pre_rst_set_min", 32'(set_min), 32'd1);
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("midrst_set_hour", 32'(set_hour), 32'd0);
      check("midrst_set_min",  32'(set_min),  32'd0);
      check("midrst_num1",     32'(set_num1), 32'd0);
      check("midrst_num2",     32'(set_num2), 32'd0);
      check("midrst_mode",     32'(mode),     32'd0);
      check("midrst_blink",    32'(blink),    32'd0);
      repeat (2) @(negedge clk);
      #3;
      rst_n = 1'b1;

      // Random button activity and counter values against the model
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
         if ($urandom_range(0, 5) == 0) btn_up = ~btn_up;
         if ($urandom_range(0, 15) == 0) begin
            cur_h1 = 4'($urandom_range(0, 3));
            cur_h2 = 4'($urandom_range(0, 11));
            cur_m1 = 4'($urandom_range(0, 7));
            cur_m2 = 4'($urandom_range(0, 11));
         end
      end
      btn_mode = 1'b0;
      btn_up   = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Front-panel time-setting controller for the digital clock. Takes two raw push-buttons (mode, up), synchronizes and debounces them, and runs an edit FSM. It drives the set_hour/set_min strobes and the shared BCD set_num1/set_num2 buses consumed by the hour and minute BCD counters. While a field is being edited, its counter is held and continuously loaded with the edited value.

Parameters:
DB_CYCLES, 50000, consecutive clk cycles a synchronized button level must be stable before the debounced level changes
TIMEOUT_CYCLES, 500000000, idle cycles in an edit state before automatic return to IDLE
BLINK_CYCLES, 25000000, half-period of the blink output in clk cycles

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_mode  in  1  raw mode button, active-high, asynchronous to clk
btn_up  in  1  raw increment button, active-high, asynchronous to clk
cur_h1  in  4  current hour tens digit (BCD), from the hour counter
cur_h2  in  4  current hour units digit (BCD)
cur_m1  in  4  current minute tens digit (BCD), from the minute counter
cur_m2  in  4  current minute units digit (BCD)
set_hour  out  1  high while in S_HOUR
set_min  out  1  high while in S_MIN
set_num1  out  4  tens digit of the field being edited
set_num2  out  4  units digit of the field being edited
mode  out  2  0=IDLE, 1=HOUR, 2=MIN, for the display driver
blink  out  1  square wave for flashing the edited field; 0 in IDLE

Behaviour:
- Reset (async, rst_n low): state=S_IDLE; all outputs 0; edit registers 0; debounced levels 0; timeout and blink counters 0.
- Button path, per button: 2-FF synchronizer, then a stability counter. The debounced level takes the synchronized value after DB_CYCLES consecutive equal cycles; any mismatch clears the counter. A press pulse is one cycle wide, on the debounced 0->1 edge only. Releases generate no pulse.
- FSM, evaluated on each clk edge:
  - S_IDLE + mode pulse -> S_HOUR. Capture edit_h from {cur_h1,cur_h2}. If the captured value is invalid BCD or >23, load 00.
  - S_HOUR + mode pulse -> S_MIN. Capture edit_m from {cur_m1,cur_m2}. If invalid or >59, load 00.
  - S_MIN + mode pulse -> S_IDLE.
  - S_HOUR + up pulse: BCD increment of edit_h. Units 9->0 with tens+1; 23->00.
  - S_MIN + up pulse: BCD increment of edit_m. Units 9->0 with tens+1; 59->00.
  - Up pulse in S_IDLE is ignored.
  - Mode and up pulses in the same cycle: mode wins, up is dropped.
  - Timeout counter clears on any pulse and on every state change. It counts in S_HOUR/S_MIN only. Reaching TIMEOUT_CYCLES-1 -> S_IDLE. The edited value already loaded into the counter is retained.
- Outputs are decoded from the state and edit registers and update on the same edge as the state change. No extra pipeline stage.
  - set_hour=(state==S_HOUR); set_min=(state==S_MIN). Never both high.
  - In S_HOUR, {set_num1,set_num2}=edit_h. In S_MIN, {set_num1,set_num2}=edit_m. In S_IDLE, both are 0.
- Latency, raw press -> state change: 2 sync cycles + DB_CYCLES + 1 cycle.
- Blink counter runs only in edit states and toggles blink every BLINK_CYCLES. Counter and blink are forced to 0 in S_IDLE and restart from 0 on entry to any edit state.
- Held button: produces exactly one pulse. There is no auto-repeat.
- Reset mid-edit: returns to S_IDLE immediately; set strobes drop asynchronously.

Decomposition:
- Package time_set_pkg:
  - State encoding S_IDLE=2'd0, S_HOUR=2'd1, S_MIN=2'd2. Encoding 2'd3 is illegal and recovers to S_IDLE.
  - BCD limits HOUR_MAX_T=2, HOUR_MAX_U=3, MIN_MAX_T=5, MIN_MAX_U=9.
  - Width helper for counter sizing, clog2 of each parameter.
- Sub-module btn_debounce (synchronizer + stability counter + rise pulse; parameter DB_CYCLES). Instantiated twice.

Test Plan:
All scenarios use DB_CYCLES=4, TIMEOUT_CYCLES=64, BLINK_CYCLES=8.
- Bounce: toggle btn_mode every 2 cycles for 20 cycles, then hold high -> exactly one mode pulse; state goes S_IDLE->S_HOUR DB_CYCLES+3 cycles after the final stable edge.
- Enter hour edit with cur=21:xx -> set_hour=1, set_num=2,1. Three up presses -> 2,2 / 2,3 / 0,0 (wrap).
- Hour units carry: cur hour 09, one up -> 1,0. Then mode -> set_min=1, set_hour=0, set_num=cur minute digits.
- Minute wrap: cur minute 58, two ups -> 5,9 then 0,0. Mode -> S_IDLE, all set outputs 0, mode=0.
- Simultaneous debounced mode+up in S_HOUR with edit_h=05 -> S_MIN entered, edit_h stays 05.
- Timeout: enter S_HOUR, no presses for 64 cycles -> S_IDLE, blink=0. Separately, assert rst_n low mid-S_MIN -> all outputs 0 within the same cycle. Invalid cur hour 2,7 on entry -> set_num=0,0.
